// File: rtl/pea_pkg.sv
// Shared types and constants for the streaming PE array and its stream-side blocks.
package pea_pkg;

  localparam int N_BITS         = 16;
  localparam int S_OUT_LEN_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } s_out_state_t;

endpackage

// File: rtl/s_out_fifo.sv
// Small synchronous FIFO with registered first-word-fall-through head (data + last flag),
// occupancy count and a synchronous flush that empties it without touching the head data.
module s_out_fifo #(
  parameter int  W     = 16,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_last,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_last,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_mem_last;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [W-1:0]     r_data;
  logic             r_last;

  logic [AW-1:0]    w_rd_nx;
  logic [CW-1:0]    w_cnt_left;
  logic [CW-1:0]    w_cnt_nx;

  assign w_rd_nx    = r_rd + AW'(i_pop);
  assign w_cnt_left = r_count - CW'(i_pop);
  assign w_cnt_nx   = w_cnt_left + CW'(i_push);

  always_ff @(posedge clk_i) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr]      <= i_data;
      r_mem_last[r_wr] <= i_last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_nx;
      r_count <= w_cnt_nx;
    end
  end

  // Head register: when the FIFO drains to empty in the same cycle it receives a word,
  // that word bypasses storage; otherwise the head comes from the next read slot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= '0;
      r_last <= 1'b0;
    end else if (!i_flush && (w_cnt_nx != '0)) begin
      if (w_cnt_left == '0) begin
        r_data <= i_data;
        r_last <= i_last;
      end else begin
        r_data <= r_mem[w_rd_nx];
        r_last <= r_mem_last[w_rd_nx];
      end
    end
  end

  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/s_out_collector.sv
// Result-stream sink for the PE array: buffers PE results, back-pressures the array, counts words per job.
// Optional stall statistics are enabled with the S_OUT_COLLECTOR_STATS_EN macro.
module s_out_collector
  import pea_pkg::*;
#(
  parameter int N_BITS = pea_pkg::N_BITS,
  parameter int DEPTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      mage_done_i,
  input  logic                      start_i,
  input  logic [S_OUT_LEN_BITS-1:0] len_i,
  input  logic [N_BITS-1:0]         pe_res_i,
  input  logic                      pe_valid_i,
  output logic                      pea_ready_o,
  output logic [N_BITS-1:0]         out_data_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      out_last_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic [15:0]               stall_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);

  s_out_state_t              r_state;
  logic [S_OUT_LEN_BITS-1:0] r_len;
  logic [S_OUT_LEN_BITS-1:0] r_pushed;
  logic                      r_ready_d1;

  logic                      w_valid;
  logic                      w_head_last;
  logic [CW-1:0]             w_count;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_last_in;
  logic                      w_start_acc;
  logic [CW:0]               w_occ_nx;
  logic [S_OUT_LEN_BITS-1:0] w_pushed_nx;

  // The PE register only changes on cycles where the array was allowed to advance,
  // so a result is fresh exactly when ready was high on the previous cycle.
  assign w_push      = (r_state == RUN) && pe_valid_i && r_ready_d1;
  assign w_pop       = w_valid && out_ready_i;
  assign w_last_in   = (r_pushed == (r_len - 16'd1));
  assign w_start_acc = start_i && (r_state == IDLE);
  assign w_occ_nx    = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_pushed_nx = r_pushed + S_OUT_LEN_BITS'(w_push);

  assign pea_ready_o = (r_state == RUN) && !mage_done_i &&
                       (w_occ_nx < (CW+1)'(DEPTH)) && (w_pushed_nx < r_len);

  s_out_fifo #(
    .W     (N_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .i_flush (mage_done_i),
    .i_push  (w_push),
    .i_data  (pe_res_i),
    .i_last  (w_last_in),
    .i_pop   (w_pop),
    .o_data  (out_data_o),
    .o_last  (w_head_last),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_pushed   <= '0;
      r_ready_d1 <= 1'b0;
    end else if (mage_done_i) begin
      r_state    <= IDLE;
      r_pushed   <= '0;
      r_ready_d1 <= 1'b0;
    end else begin
      r_ready_d1 <= pea_ready_o;
      r_pushed   <= w_pushed_nx;
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            r_len    <= len_i;
            r_pushed <= '0;
            r_state  <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_pushed_nx == r_len) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_occ_nx == '0) r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid_o = w_valid;
  assign out_last_o  = w_valid && w_head_last;
  assign done_o      = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);

`ifdef S_OUT_COLLECTOR_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt <= '0;
    end else if (mage_done_i || w_start_acc) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && !pea_ready_o && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
